// File: rtl/rs_ccff_pkg.sv
// Shared types and command encoding for the CCFF configuration chain and its loader.
package rs_ccff_pkg;

  typedef enum logic [1:0] {
    CCFF_IDLE  = 2'b00,
    CCFF_SHIFT = 2'b01,
    CCFF_FULL  = 2'b10
  } ccff_state_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_SHIFT = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  // Shift wins over load, load wins over readback.
  function automatic logic [1:0] ccff_cmd(input logic se, input logic load, input logic read);
    logic [1:0] cmd;
    if (se) begin
      cmd = CMD_SHIFT;
    end else if (load) begin
      cmd = CMD_LOAD;
    end else if (read) begin
      cmd = CMD_READ;
    end else begin
      cmd = CMD_NONE;
    end
    return cmd;
  endfunction

  function automatic logic ccff_collision(input logic se, input logic load, input logic read);
    return (se & (load | read)) | (load & read);
  endfunction

endpackage

// File: rtl/rs_ccff_chain_ctl.sv
// Control for one CCFF segment: chain state, modulo bit counter and sticky error flag.
module rs_ccff_chain_ctl
  import rs_ccff_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             se_i,
  input  logic             load_i,
  input  logic             read_i,
  output ccff_state_t      state_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o,
  output logic             shift_o,
  output logic             load_o,
  output logic             read_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  ccff_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [1:0]       cmd_s;

  assign cmd_s = ccff_cmd(se_i, load_i, read_i);

  // Next state, counter and error, plus datapath strobes for the top level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q | ccff_collision(se_i, load_i, read_i);
    shift_o = 1'b0;
    load_o  = 1'b0;
    read_o  = 1'b0;
    case (cmd_s)
      CMD_SHIFT: begin
        shift_o = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = CCFF_FULL;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (state_q == CCFF_FULL) begin
            state_d = CCFF_FULL;
          end else begin
            state_d = CCFF_SHIFT;
          end
        end
      end
      CMD_LOAD: begin
        // Loading a partially shifted bitstream would corrupt live config.
        if (state_q == CCFF_FULL) begin
          load_o  = 1'b1;
          state_d = CCFF_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          err_d = 1'b1;
        end
      end
      CMD_READ: begin
        read_o  = 1'b1;
        state_d = CCFF_IDLE;
        cnt_d   = CNT_ZERO;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CCFF_IDLE;
      cnt_q   <= CNT_ZERO;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign state_o = state_q;
  assign cnt_o   = cnt_q;
  assign err_o   = err_q;

endmodule

// File: rtl/rs_ccff_chain.sv
// Configuration-chain segment: serial shift register with a shadow MEM register that only
// changes on a legal load, so datapath config stays stable while a new bitstream streams through.
module rs_ccff_chain
  import rs_ccff_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] MEM_RST = {WIDTH{1'b0}},
  localparam int              CNT_W   = $clog2(WIDTH)
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             D,
  input  logic             SE,
  input  logic             CFG_LOAD,
  input  logic             CFG_READ,
  output logic             Q,
  output logic [WIDTH-1:0] MEM,
  output logic             FULL,
  output logic             ERR,
  output logic [CNT_W-1:0] CNT
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] mem_q, mem_d;
  ccff_state_t      state_s;
  logic             shift_s, load_s, read_s;

  rs_ccff_chain_ctl #(
    .WIDTH(WIDTH)
  ) u_ctl (
    .clk_i  (CK),
    .rst_ni (RN),
    .se_i   (SE),
    .load_i (CFG_LOAD),
    .read_i (CFG_READ),
    .state_o(state_s),
    .cnt_o  (CNT),
    .err_o  (ERR),
    .shift_o(shift_s),
    .load_o (load_s),
    .read_o (read_s)
  );

  // Shift register and shadow register next-state.
  always_comb begin
    sr_d  = sr_q;
    mem_d = mem_q;
    if (shift_s) begin
      sr_d = {sr_q[WIDTH-2:0], D};
    end else if (read_s) begin
      sr_d = mem_q;
    end else begin
      sr_d = sr_q;
    end
    if (load_s) begin
      mem_d = sr_q;
    end else begin
      mem_d = mem_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      sr_q  <= {WIDTH{1'b0}};
      mem_q <= MEM_RST;
    end else begin
      sr_q  <= sr_d;
      mem_q <= mem_d;
    end
  end

  assign Q    = sr_q[WIDTH-1];
  assign MEM  = mem_q;
  assign FULL = (state_s == CCFF_FULL);

endmodule

// File: tb/tb_rs_ccff_chain.sv
// Self-checking bench for rs_ccff_chain (WIDTH=16) with a bit-count based reference model.
module tb_rs_ccff_chain;

  localparam logic [15:0] RSTV = 16'h5A0F;

  logic        CK = 1'b0;
  logic        RN = 1'b1;
  logic        D = 1'b0, SE = 1'b0, CFG_LOAD = 1'b0, CFG_READ = 1'b0;
  logic        Q, FULL, ERR;
  logic [15:0] MEM;
  logic [3:0]  CNT;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [15:0] m_sr = 16'h0000;
  logic [15:0] m_mem = RSTV;
  int          m_n = 0;
  logic        m_err = 1'b0;

  rs_ccff_chain #(.WIDTH(16), .MEM_RST(RSTV)) dut (
    .CK(CK), .RN(RN), .D(D), .SE(SE), .CFG_LOAD(CFG_LOAD), .CFG_READ(CFG_READ),
    .Q(Q), .MEM(MEM), .FULL(FULL), .ERR(ERR), .CNT(CNT)
  );

  always #5 CK = ~CK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: m_n counts bits shifted since reset/load/read.
  always @(posedge CK or negedge RN) begin
    if (!RN) begin
      m_sr  <= 16'h0000;
      m_mem <= RSTV;
      m_n   <= 0;
      m_err <= 1'b0;
    end else if (SE) begin
      m_sr <= {m_sr[14:0], D};
      m_n  <= m_n + 1;
      if (CFG_LOAD || CFG_READ) m_err <= 1'b1;
    end else if (CFG_LOAD) begin
      if (m_n >= 16) begin
        m_mem <= m_sr;
        m_n   <= 0;
      end
      if (m_n < 16 || CFG_READ) m_err <= 1'b1;
    end else if (CFG_READ) begin
      m_sr <= m_mem;
      m_n  <= 0;
    end
  end

  always @(negedge CK) begin
    if (chk_en) begin
      chk("q", 32'(Q), 32'(m_sr[15]));
      chk("mem", 32'(MEM), 32'(m_mem));
      chk("full", 32'(FULL), 32'(m_n >= 16));
      chk("cnt", 32'(CNT), 32'(m_n % 16));
      chk("err", 32'(ERR), 32'(m_err));
    end
  end

  task automatic cyc(input logic se, input logic d, input logic ld, input logic rd);
    SE = se; D = d; CFG_LOAD = ld; CFG_READ = rd;
    @(negedge CK);
    #1;
  endtask

  initial begin
    logic [15:0] v;
    logic [19:0] p;
    logic [15:0] got;

    #2 RN = 1'b0;
    #1;
    chk("rst_mem", 32'(MEM), 32'h5A0F);
    chk("rst_q", 32'(Q), 32'h0);
    chk("rst_cnt", 32'(CNT), 32'h0);
    chk("rst_full", 32'(FULL), 32'h0);
    chk("rst_err", 32'(ERR), 32'h0);
    @(negedge CK);
    #1;
    RN = 1'b1;
    chk_en = 1'b1;

    v = 16'hA5C3;
    for (int i = 15; i >= 0; i--) cyc(1'b1, v[i], 1'b0, 1'b0);
    chk("full_after16", 32'(FULL), 32'h1);
    chk("cnt_after16", 32'(CNT), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("load_mem", 32'(MEM), 32'hA5C3);
    chk("load_full", 32'(FULL), 32'h0);
    chk("load_cnt", 32'(CNT), 32'h0);
    chk("load_err", 32'(ERR), 32'h0);

    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("early_load_err", 32'(ERR), 32'h1);
    chk("early_load_mem", 32'(MEM), 32'hA5C3);
    chk("early_load_cnt", 32'(CNT), 32'h8);
    chk("early_load_q", 32'(Q), 32'h1);

    SE = 1'b1; D = 1'b1;
    #2 RN = 1'b0;
    #1;
    chk("async_mem", 32'(MEM), 32'h5A0F);
    chk("async_q", 32'(Q), 32'h0);
    chk("async_cnt", 32'(CNT), 32'h0);
    chk("async_full", 32'(FULL), 32'h0);
    chk("async_err", 32'(ERR), 32'h0);
    @(negedge CK);
    #1;
    RN = 1'b1;

    p = 20'hB37C5;
    for (int k = 1; k <= 20; k++) begin
      if (k >= 17) chk("pass_q", 32'(Q), 32'(p[36 - k]));
      cyc(1'b1, p[20 - k], 1'b0, 1'b0);
    end
    chk("over_full", 32'(FULL), 32'h1);
    chk("over_cnt", 32'(CNT), 32'h4);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("over_load_mem", 32'(MEM), 32'h37C5);
    chk("over_load_err", 32'(ERR), 32'h0);

    v = 16'h1234;
    for (int i = 15; i >= 0; i--) cyc(1'b1, v[i], 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("mem_1234", 32'(MEM), 32'h1234);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("read_cnt", 32'(CNT), 32'h0);
    chk("read_full", 32'(FULL), 32'h0);
    got = 16'h0000;
    for (int i = 15; i >= 0; i--) begin
      got[i] = Q;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("readback_stream", 32'(got), 32'h1234);
    chk("readback_mem", 32'(MEM), 32'h1234);
    chk("readback_full", 32'(FULL), 32'h1);

    chk("pre_collide_err", 32'(ERR), 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("collide_err", 32'(ERR), 32'h1);
    chk("collide_mem", 32'(MEM), 32'h1234);
    chk("collide_cnt", 32'(CNT), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
